// File: rtl/neo_pattern_sequencer.sv
// Pattern sequencer for a serial RGB pixel strip: generates per-pixel/per-color
// load strobes, then send requests, repeating each frame before stepping the pattern.

module neo_level_lane #(
    parameter int LEVEL_W = 8,
    parameter int PW      = 3,
    parameter int PIX     = 0
) (
    input  logic [1:0]         color,
    input  logic [1:0]         step2,
    input  logic [PW-1:0]      chase,
    input  logic [1:0]         mode,
    input  logic               en,
    output logic [LEVEL_W-1:0] level
);
    localparam logic [PW-1:0] PIX_V = PW'(PIX);
    localparam logic [1:0]    PIX_2 = 2'(PIX % 4);
    localparam logic          PIX_0 = 1'(PIX % 2);

    function automatic logic [7:0] lvl_code(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h00;
            2'd1:    return 8'h05;
            2'd2:    return 8'h10;
            default: return 8'h20;
        endcase
    endfunction

    logic [7:0] code;
    logic       odd;

    always_comb begin
        code = 8'h00;
        odd  = PIX_0 ^ step2[0];
        case (mode)
            2'd0:    code = lvl_code(PIX_2 + color);
            2'd1:    code = (chase == PIX_V) ? 8'h20 : 8'h00;
            2'd2:    code = lvl_code(step2 + color);
            default: code = (odd ? (color == 2'd2) : (color == 2'd1)) ? 8'h10 : 8'h00;
        endcase
        level = en ? LEVEL_W'(code) : '0;
    end
endmodule

module neo_pattern_sequencer #(
    parameter int NUM_PIXELS    = 5,
    parameter int LEVEL_W       = 8,
    parameter int REPEAT_FRAMES = 4,
    parameter int NUM_STEPS     = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          run,
    input  logic [1:0]                    mode,
    input  logic [NUM_PIXELS-1:0]         syncedSW,
    input  logic                          ready_to_load,
    input  logic                          ready_to_send,
    input  logic                          done_wait,
    output logic [$clog2(NUM_PIXELS)-1:0] pixel_index,
    output logic [1:0]                    color_index,
    output logic [LEVEL_W-1:0]            color_level,
    output logic                          load_color,
    output logic                          send_it,
    output logic                          frame_done,
    output logic [$clog2(NUM_STEPS)-1:0]  step
);
    localparam int PW = $clog2(NUM_PIXELS);
    localparam int SW = $clog2(NUM_STEPS);
    localparam int RW = $clog2(REPEAT_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_SEND, SENDING} state_t;

    typedef struct packed {
        logic [PW-1:0]      pixel;
        logic [1:0]         color;
        logic [LEVEL_W-1:0] level;
        logic               strobe;
    } load_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [1:0]    col_q, col_d;
    logic [SW-1:0] step_q, step_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [1:0]    mode_q, mode_d;
    // chase_q tracks step mod NUM_PIXELS so chase mode needs no divider
    logic [PW-1:0] chase_q, chase_d;
    load_t         ld;

    logic [NUM_PIXELS-1:0][LEVEL_W-1:0] lane_lvl;

    for (genvar g = 0; g < NUM_PIXELS; g++) begin : g_lane
        neo_level_lane #(.LEVEL_W(LEVEL_W), .PW(PW), .PIX(g)) u_lane (
            .color (col_q),
            .step2 (step_q[1:0]),
            .chase (chase_q),
            .mode  (mode_q),
            .en    (syncedSW[g]),
            .level (lane_lvl[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pix_q   <= '0;
            col_q   <= '0;
            step_q  <= '0;
            rep_q   <= '0;
            mode_q  <= '0;
            chase_q <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            col_q   <= col_d;
            step_q  <= step_d;
            rep_q   <= rep_d;
            mode_q  <= mode_d;
            chase_q <= chase_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        col_d      = col_q;
        step_d     = step_q;
        rep_d      = rep_q;
        mode_d     = mode_q;
        chase_d    = chase_q;
        ld         = '0;
        send_it    = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    mode_d  = mode;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ld.pixel  = pix_q;
                ld.color  = col_q;
                ld.level  = lane_lvl[pix_q];
                ld.strobe = ready_to_load;
                if (ready_to_load) begin
                    if (col_q == 2'd2) begin
                        col_d = 2'd0;
                        if (pix_q == PW'(NUM_PIXELS - 1)) begin
                            pix_d   = '0;
                            state_d = WAIT_SEND;
                        end else begin
                            pix_d = pix_q + PW'(1);
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            WAIT_SEND: begin
                send_it = ready_to_send;
                if (ready_to_send) state_d = SENDING;
            end
            SENDING: begin
                if (done_wait) begin
                    frame_done = 1'b1;
                    if (rep_q == RW'(REPEAT_FRAMES - 1)) begin
                        rep_d  = '0;
                        step_d = step_q + SW'(1);
                        if (step_q == SW'(NUM_STEPS - 1) || chase_q == PW'(NUM_PIXELS - 1))
                            chase_d = '0;
                        else
                            chase_d = chase_q + PW'(1);
                        if (run) begin
                            mode_d  = mode;
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        rep_d   = rep_q + RW'(1);
                        state_d = run ? WAIT_SEND : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pixel_index = ld.pixel;
    assign color_index = ld.color;
    assign color_level = ld.level;
    assign load_color  = ld.strobe;
    assign step        = step_q;
endmodule
